// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button debouncer slice.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_HIGH,
        S_HIGH,
        S_WAIT_LOW
    } db_state_t;

    localparam int DEFAULT_STABLE_CYCLES = 1_000_000;

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: 2-flop synchroniser, stability counter and level FSM
// producing a clean level plus one-cycle press/release pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    // A reversal in either WAIT state drops back to the steady state, so the
    // count always restarts from the most recent transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= S_LOW;
            cnt   <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            case (state)
                S_LOW: begin
                    if (sync2) begin
                        state <= S_WAIT_HIGH;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                S_WAIT_HIGH: begin
                    if (!sync2) begin
                        state <= S_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                        db    <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!sync2) begin
                        state <= S_WAIT_LOW;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                S_WAIT_LOW: begin
                    if (sync2) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_LOW;
                        cnt   <= '0;
                        db    <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= S_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debouncer.sv
// Debounces the board push-buttons; one independent channel per button,
// feeding the LED/switch group-masking stage.
module btn_debouncer
    import debounce_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] btn_db_o,
    output logic [N_BTN-1:0] btn_rise_o,
    output logic [N_BTN-1:0] btn_fall_o
);

    // The accept compare against STABLE_CYCLES-1 needs at least one counted cycle.
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("btn_debouncer: STABLE_CYCLES must be >= 2");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_channel (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn_i[i]),
            .db   (btn_db_o[i]),
            .rise (btn_rise_o[i]),
            .fall (btn_fall_o[i])
        );
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with STABLE_CYCLES=4; outputs sampled on
// the falling edge, inputs changed on the falling edge.
module tb_btn_debouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_i;
    logic [3:0] btn_db_o;
    logic [3:0] btn_rise_o;
    logic [3:0] btn_fall_o;

    int assert_count = 0;
    int fail_count   = 0;

    btn_debouncer #(
        .N_BTN        (4),
        .STABLE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_i     (btn_i),
        .btn_db_o  (btn_db_o),
        .btn_rise_o(btn_rise_o),
        .btn_fall_o(btn_fall_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [11:0] observed,
                               input logic [11:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got db/rise/fall=%h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_val, input logic [3:0] btn_val);
        rst_n = rst_val;
        btn_i = btn_val;
    endtask

    // Runs ncyc cycles; the accepting edge is observed on cycle 'hit' (0 = none).
    task automatic runPhase(input string tag, input int ncyc, input int hit,
                            input logic [3:0] db_before, input logic [3:0] db_after,
                            input logic [3:0] rise_mask, input logic [3:0] fall_mask);
        logic [3:0] exp_db;
        logic [3:0] exp_rise;
        logic [3:0] exp_fall;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            exp_db   = (hit != 0 && k >= hit) ? db_after : db_before;
            exp_rise = (k == hit) ? rise_mask : 4'b0000;
            exp_fall = (k == hit) ? fall_mask : 4'b0000;
            checkOutput($sformatf("%s[%0d]", tag, k),
                        {btn_db_o, btn_rise_o, btn_fall_o},
                        {exp_db, exp_rise, exp_fall});
        end
    endtask

    initial begin
        applyStimulus(1'b0, 4'b1111);
        runPhase("reset", 3, 0, 4'h0, 4'h0, 4'h0, 4'h0);

        applyStimulus(1'b1, 4'b0000);
        runPhase("idle", 3, 0, 4'h0, 4'h0, 4'h0, 4'h0);

        applyStimulus(1'b1, 4'b0001);
        runPhase("press0", 8, 6, 4'h0, 4'h1, 4'h1, 4'h0);

        applyStimulus(1'b1, 4'b0101);
        runPhase("glitch_hi", 3, 0, 4'h1, 4'h1, 4'h0, 4'h0);
        applyStimulus(1'b1, 4'b0001);
        runPhase("glitch_lo", 8, 0, 4'h1, 4'h1, 4'h0, 4'h0);

        applyStimulus(1'b1, 4'b0011);
        runPhase("bounce_a", 1, 0, 4'h1, 4'h1, 4'h0, 4'h0);
        applyStimulus(1'b1, 4'b0001);
        runPhase("bounce_b", 1, 0, 4'h1, 4'h1, 4'h0, 4'h0);
        applyStimulus(1'b1, 4'b0011);
        runPhase("bounce_c", 1, 0, 4'h1, 4'h1, 4'h0, 4'h0);
        applyStimulus(1'b1, 4'b0001);
        runPhase("bounce_d", 1, 0, 4'h1, 4'h1, 4'h0, 4'h0);
        applyStimulus(1'b1, 4'b0011);
        runPhase("bounce_hold", 8, 6, 4'h1, 4'h3, 4'h2, 4'h0);

        applyStimulus(1'b1, 4'b0000);
        runPhase("release", 8, 6, 4'h3, 4'h0, 4'h0, 4'h3);

        applyStimulus(1'b1, 4'b1111);
        runPhase("all_press", 8, 6, 4'h0, 4'hF, 4'hF, 4'h0);
        applyStimulus(1'b1, 4'b0000);
        runPhase("all_release", 8, 6, 4'hF, 4'h0, 4'h0, 4'hF);

        applyStimulus(1'b1, 4'b1111);
        runPhase("pre_reset", 3, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        applyStimulus(1'b0, 4'b1111);
        runPhase("mid_reset", 3, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        applyStimulus(1'b1, 4'b1111);
        runPhase("held_thru_reset", 8, 6, 4'h0, 4'hF, 4'hF, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/btn_debouncer.md
Name: btn_debouncer

Overview:
Upstream conditioning stage for the four board push-buttons; its btn_db_o output drives the btn input of the LED/switch group-masking stage.
- Synchronises each raw asynchronous button into the clk domain.
- Filters contact bounce with a per-channel stability counter and FSM.
- Emits the clean level plus one-cycle press/release pulses.
- Channels are fully independent; no cross-channel interaction.

Parameters:
N_BTN, 4, number of button channels.
STABLE_CYCLES, 1_000_000, consecutive synchronized cycles at a new level before it is accepted (10 ms at 100 MHz); benches override to 4.
CNT_W, $clog2(STABLE_CYCLES+1), counter width (derived, not overridden).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
btn_i  input  N_BTN  raw asynchronous button levels, 1 = pressed.
btn_db_o  output  N_BTN  debounced level per channel.
btn_rise_o  output  N_BTN  one-cycle pulse on accepted press.
btn_fall_o  output  N_BTN  one-cycle pulse on accepted release.

Behaviour:
- Clock and reset are fixed: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a rising edge), per channel:
  - both synchroniser flops, counter, btn_db_o, btn_rise_o and btn_fall_o go to 0;
  - FSM goes to S_LOW;
  - btn_i is ignored while reset is asserted.
- Synchroniser: 2-flop chain, sync1 <= btn_i, sync2 <= sync1. Only sync2 feeds the FSM.
- Per-channel FSM states: S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW.
- S_LOW:
  - sync2=1 -> S_WAIT_HIGH, cnt <= 1.
  - else stay, cnt <= 0.
- S_WAIT_HIGH:
  - sync2=0 -> S_LOW, cnt <= 0 (glitch rejected, no pulse).
  - sync2=1 and cnt == STABLE_CYCLES-1 -> S_HIGH; btn_db_o <= 1; btn_rise_o <= 1 for exactly that one cycle.
  - else cnt <= cnt+1.
- S_HIGH and S_WAIT_LOW mirror the above with levels inverted; acceptance sets btn_db_o <= 0 and pulses btn_fall_o.
- Latency:
  - a clean raw edge first sampled at edge E changes btn_db_o at edge E+STABLE_CYCLES+1 (2 sync stages plus STABLE_CYCLES counted cycles, sharing one edge);
  - with STABLE_CYCLES=4, btn_db_o changes 5 edges after E.
- Glitch rejection: any excursion at sync2 shorter than STABLE_CYCLES cycles produces no output change and no pulse.
- Bounce: every reversal during a WAIT state restarts the count from the steady state. Latency is therefore measured from the last transition.
- Output rules:
  - btn_rise_o and btn_fall_o are registered, never high in the same cycle for one channel, and never high for 2 consecutive cycles.
  - btn_db_o is registered and only changes in a pulse cycle.
- Simultaneous channels: channels accepting on the same edge pulse on the same cycle.
- Reset mid-WAIT: the next edge forces all outputs to 0 with no pulse. A button held through reset release is re-debounced from S_LOW and yields a normal rise pulse after full latency.
- Counter: never exceeds STABLE_CYCLES-1; no wrap-around is possible.
- Elaboration check: STABLE_CYCLES >= 2; otherwise $error.

Decomposition:
- Package debounce_pkg holds:
  - typedef enum logic [1:0] db_state_t {S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW};
  - localparam DEFAULT_STABLE_CYCLES = 1_000_000.
- Sub-module debounce_channel: one synchroniser, FSM and counter for a single bit.
- btn_debouncer instantiates N_BTN copies of debounce_channel in a generate loop.

Test Plan:
All scenarios use STABLE_CYCLES=4.
1. Reset held 3 cycles with btn_i=4'b1111 -> btn_db_o, btn_rise_o and btn_fall_o all 4'b0000 during reset.
2. After reset, btn_i=4'b0001 first sampled at edge E -> btn_db_o=4'b0001 at E+5; btn_rise_o=4'b0001 for exactly that one cycle; all other bits stay 0.
3. btn_i[2] high for 3 cycles, then low -> btn_db_o[2] stays 0; no pulses on any channel.
4. btn_i[1] toggles 1,0,1,0,1 on successive cycles, then holds 1 -> btn_db_o[1] rises 5 edges after the final 0->1 sample, with a single btn_rise_o[1] pulse.
5. From 4'b0001 debounced, drop btn_i to 4'b0000 -> btn_db_o[0] falls 5 edges later; btn_fall_o[0] pulses once; btn_rise_o stays 0.
6. btn_i=4'b1111 applied in one cycle -> all four btn_rise_o bits pulse on the same edge. Repeating the press with rst_n=0 asserted at E+3 -> outputs stay 0 and no pulse appears; after rst_n=1 with buttons still held, rise occurs after full latency.
